// File: rtl/ilv_pkg.sv
// Shared constants and types for the 802.11a interleaver bank controller.
// Rate codes, modulation encoding, pairs per symbol and read-FSM states.
package ilv_pkg;

   localparam logic [3:0] RATE_6  = 4'b1101;
   localparam logic [3:0] RATE_9  = 4'b1111;
   localparam logic [3:0] RATE_12 = 4'b0101;
   localparam logic [3:0] RATE_18 = 4'b0111;
   localparam logic [3:0] RATE_24 = 4'b1001;
   localparam logic [3:0] RATE_36 = 4'b1011;
   localparam logic [3:0] RATE_48 = 4'b0001;
   localparam logic [3:0] RATE_54 = 4'b0011;

   typedef enum logic [1:0] {
      MOD_BPSK  = 2'd0,
      MOD_QPSK  = 2'd1,
      MOD_16QAM = 2'd2,
      MOD_64QAM = 2'd3
   } mod_e;

   localparam logic [7:0] NPAIR_BPSK  = 8'd24;
   localparam logic [7:0] NPAIR_QPSK  = 8'd48;
   localparam logic [7:0] NPAIR_16QAM = 8'd96;
   localparam logic [7:0] NPAIR_64QAM = 8'd144;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_READ = 1'b1
   } rd_state_e;

endpackage

// File: rtl/ilv_rate_decode.sv
// Combinational RATE code decoder: legality, modulation and pairs per symbol.
// Every code outside the eight 802.11a rates is reported as illegal.
module ilv_rate_decode
   import ilv_pkg::*;
(
   input  logic [3:0] i_rate,
   output logic       o_legal,
   output mod_e       o_mod,
   output logic [7:0] o_npair
);

   always_comb begin
      o_legal = 1'b1;
      o_mod   = MOD_BPSK;
      o_npair = NPAIR_BPSK;
      case (i_rate)
         RATE_6, RATE_9: begin
            o_mod   = MOD_BPSK;
            o_npair = NPAIR_BPSK;
         end
         RATE_12, RATE_18: begin
            o_mod   = MOD_QPSK;
            o_npair = NPAIR_QPSK;
         end
         RATE_24, RATE_36: begin
            o_mod   = MOD_16QAM;
            o_npair = NPAIR_16QAM;
         end
         RATE_48, RATE_54: begin
            o_mod   = MOD_64QAM;
            o_npair = NPAIR_64QAM;
         end
         default: begin
            o_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ilv_bank_ctrl.sv
// Ping-pong bank controller between the convolutional encoder and the
// interleaver permutation stage; one bank fills while the other is read.
module ilv_bank_ctrl
   import ilv_pkg::*;
#(
   parameter int ADDR_W = 8
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        rate,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              rd_en,
   output logic              rd_bank,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [1:0]        rd_mod,
   output logic              out_valid,
   output logic              sym_start,
   output logic              rate_err
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic              w_legal;
   mod_e              w_dec_mod;
   logic [7:0]        w_dec_npair;

   logic              r_wb;
   logic              r_rb;
   logic [1:0]        r_full;
   mod_e              r_mod   [2];
   logic [ADDR_W-1:0] r_npair [2];
   logic [ADDR_W-1:0] r_wcnt;
   logic [ADDR_W-1:0] r_rcnt;
   rd_state_e         r_state;
   logic              r_out_valid;
   logic              r_sym_start;

   rd_state_e         w_next;
   logic [1:0]        w_full_nxt;
   logic              w_wr_first;
   logic [ADDR_W-1:0] w_wr_npair;
   logic              w_wr_last;
   logic              w_reading;
   logic              w_rd_last;
   logic              w_bank_busy;
   logic              w_ready;
   logic              w_xfer;
   logic              w_set;
   logic              w_other_full;

   ilv_rate_decode u_dec (
      .i_rate  (rate),
      .o_legal (w_legal),
      .o_mod   (w_dec_mod),
      .o_npair (w_dec_npair)
   );

   // The first pair of a symbol uses the live decode; later pairs the latched size.
   assign w_wr_first = (r_wcnt == '0);
   assign w_wr_npair = w_wr_first ? ADDR_W'(w_dec_npair) : r_npair[r_wb];
   assign w_wr_last  = (r_wcnt == w_wr_npair - ONE);

   assign w_reading  = (r_state == RD_READ);
   assign w_rd_last  = w_reading && (r_rcnt == r_npair[r_rb] - ONE);

   // A bank whose last pair is read this cycle may take its first new pair.
   assign w_bank_busy = r_full[r_wb] && !(w_rd_last && (r_rb == r_wb));
   assign w_ready     = !reset && !w_bank_busy && (!w_wr_first || w_legal);
   assign w_xfer      = in_valid && w_ready;
   assign w_set       = w_xfer && w_wr_last;
   assign w_other_full = r_full[~r_rb] || (w_set && (r_wb != r_rb));

   always_comb begin
      w_full_nxt = r_full;
      if (w_rd_last) w_full_nxt[r_rb] = 1'b0;
      if (w_set)     w_full_nxt[r_wb] = 1'b1;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RD_IDLE: if (r_full[r_rb]) w_next = RD_READ;
         RD_READ: if (w_rd_last && !w_other_full) w_next = RD_IDLE;
         default: w_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= RD_IDLE;
         r_wb        <= 1'b0;
         r_rb        <= 1'b0;
         r_full      <= 2'b00;
         r_mod[0]    <= MOD_BPSK;
         r_mod[1]    <= MOD_BPSK;
         r_npair[0]  <= '0;
         r_npair[1]  <= '0;
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_out_valid <= 1'b0;
         r_sym_start <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_full      <= w_full_nxt;
         r_out_valid <= w_reading;
         r_sym_start <= w_reading && (r_rcnt == '0);
         if (w_xfer) begin
            if (w_wr_first) begin
               r_mod[r_wb]   <= w_dec_mod;
               r_npair[r_wb] <= ADDR_W'(w_dec_npair);
            end
            if (w_wr_last) begin
               r_wcnt <= '0;
               r_wb   <= ~r_wb;
            end else begin
               r_wcnt <= r_wcnt + ONE;
            end
         end
         if (w_reading) begin
            if (w_rd_last) begin
               r_rcnt <= '0;
               r_rb   <= ~r_rb;
            end else begin
               r_rcnt <= r_rcnt + ONE;
            end
         end
      end
   end

   assign in_ready  = w_ready;
   assign wr_en     = w_xfer;
   assign wr_bank   = r_wb && !reset;
   assign wr_addr   = reset ? '0 : r_wcnt;
   assign rd_en     = w_reading && !reset;
   assign rd_bank   = r_rb && !reset;
   assign rd_addr   = reset ? '0 : r_rcnt;
   assign rd_mod    = reset ? 2'b00 : 2'(r_mod[r_rb]);
   assign out_valid = r_out_valid && !reset;
   assign sym_start = r_sym_start && !reset;
   assign rate_err  = !reset && in_valid && w_wr_first && !w_legal && !w_bank_busy;

endmodule

// File: tb/tb_ilv_bank_ctrl.sv
// Directed bench for ilv_bank_ctrl: fill/read timing, rates, stalls, reset.
// Expected values are hand-derived cycle windows relative to the first write.
module tb_ilv_bank_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] rate;
   logic       in_valid;
   logic       in_ready;
   logic       wr_en;
   logic       wr_bank;
   logic [7:0] wr_addr;
   logic       rd_en;
   logic       rd_bank;
   logic [7:0] rd_addr;
   logic [1:0] rd_mod;
   logic       out_valid;
   logic       sym_start;
   logic       rate_err;

   int total;
   int bad;

   ilv_bank_ctrl #(.ADDR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .rate      (rate),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_bank   (wr_bank),
      .wr_addr   (wr_addr),
      .rd_en     (rd_en),
      .rd_bank   (rd_bank),
      .rd_addr   (rd_addr),
      .rd_mod    (rd_mod),
      .out_valid (out_valid),
      .sym_start (sym_start),
      .rate_err  (rate_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      rate = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] got;
      apply_reset();
      in_valid = 1'b1;
      rate = 4'b1001;
      #1;
      got = {in_ready, wr_en, rd_en, out_valid, sym_start, rate_err,
             wr_bank, rd_bank, rd_mod, wr_addr, rd_addr, 6'd0};
      total++;
      if (got !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs: got=%h want=0", got);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got=%b want=1", in_ready);
      end
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 8'd0 || wr_bank !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_wr: got=%b/%0d/%b want=1/0/0",
                  wr_en, wr_addr, wr_bank);
      end
   endtask

   task automatic test_16qam();
      int first_rd, wr_bad, rd_bad, ov_bad, ss_bad;
      logic exp_wr, exp_rd;
      apply_reset();
      first_rd = -1;
      wr_bad = 0; rd_bad = 0; ov_bad = 0; ss_bad = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         reset = 1'b0;
         rate = 4'b1001;
         in_valid = (k < 192);
         #1;
         exp_wr = (k < 192);
         if (wr_en !== exp_wr) wr_bad++;
         if (exp_wr && (wr_addr !== 8'(k % 96) || wr_bank !== 1'(k / 96)
                        || in_ready !== 1'b1)) wr_bad++;
         exp_rd = (k >= 97 && k <= 288);
         if (rd_en !== exp_rd) rd_bad++;
         if (exp_rd && (rd_addr !== 8'((k - 97) % 96)
                        || rd_bank !== 1'((k - 97) / 96)
                        || rd_mod !== 2'd2)) rd_bad++;
         if (rd_en === 1'b1 && first_rd < 0) first_rd = k;
         if (out_valid !== (k >= 98 && k <= 289)) ov_bad++;
         if (sym_start !== (k == 98 || k == 194)) ss_bad++;
      end
      total++;
      if (first_rd !== 97) begin
         bad++;
         $display("FAIL qam16_first_rd: got=%0d want=97", first_rd);
      end
      total++;
      if (wr_bad !== 0) begin
         bad++;
         $display("FAIL qam16_writes: got=%0d bad cycles want=0", wr_bad);
      end
      total++;
      if (rd_bad !== 0) begin
         bad++;
         $display("FAIL qam16_reads: got=%0d bad cycles want=0", rd_bad);
      end
      total++;
      if (ov_bad !== 0) begin
         bad++;
         $display("FAIL qam16_out_valid: got=%0d bad cycles want=0", ov_bad);
      end
      total++;
      if (ss_bad !== 0) begin
         bad++;
         $display("FAIL qam16_sym_start: got=%0d bad cycles want=0", ss_bad);
      end
   endtask

   task automatic test_back_to_back();
      int wr_bad, rd_bad, rdy_bad, ss_cnt;
      logic exp_rd;
      apply_reset();
      wr_bad = 0; rd_bad = 0; rdy_bad = 0; ss_cnt = 0;
      for (int k = 0; k < 290; k++) begin
         @(negedge clk);
         reset = 1'b0;
         rate = 4'b1101;
         in_valid = (k < 240);
         #1;
         if (k < 240) begin
            if (in_ready !== 1'b1) rdy_bad++;
            if (wr_en !== 1'b1 || wr_addr !== 8'(k % 24)
                || wr_bank !== 1'((k / 24) % 2)) wr_bad++;
         end else if (wr_en !== 1'b0) wr_bad++;
         exp_rd = (k >= 25 && k <= 264);
         if (rd_en !== exp_rd) rd_bad++;
         if (exp_rd && (rd_addr !== 8'((k - 25) % 24)
                        || rd_bank !== 1'(((k - 25) / 24) % 2)
                        || rd_mod !== 2'd0)) rd_bad++;
         if (sym_start === 1'b1) ss_cnt++;
      end
      total++;
      if (rdy_bad !== 0) begin
         bad++;
         $display("FAIL b2b_in_ready: got=%0d low cycles want=0", rdy_bad);
      end
      total++;
      if (wr_bad !== 0) begin
         bad++;
         $display("FAIL b2b_writes: got=%0d bad cycles want=0", wr_bad);
      end
      total++;
      if (rd_bad !== 0) begin
         bad++;
         $display("FAIL b2b_reads: got=%0d bad cycles want=0", rd_bad);
      end
      total++;
      if (ss_cnt !== 10) begin
         bad++;
         $display("FAIL b2b_sym_count: got=%0d want=10", ss_cnt);
      end
   endtask

   task automatic test_rate_change();
      int wr_bad, rd_bad, n0, n1;
      apply_reset();
      wr_bad = 0; rd_bad = 0; n0 = 0; n1 = 0;
      for (int k = 0; k < 330; k++) begin
         @(negedge clk);
         reset = 1'b0;
         if (k < 10) rate = 4'b0001;
         else if (k < 144) rate = 4'b1011;
         else if (k < 150) rate = 4'b1101;
         else rate = 4'b0011;
         in_valid = (k < 168);
         #1;
         if (k < 144) begin
            if (wr_en !== 1'b1 || wr_bank !== 1'b0 || wr_addr !== 8'(k)) wr_bad++;
         end else if (k < 168) begin
            if (wr_en !== 1'b1 || wr_bank !== 1'b1
                || wr_addr !== 8'(k - 144)) wr_bad++;
         end else if (wr_en !== 1'b0) wr_bad++;
         if (k >= 145 && k <= 288) begin
            if (rd_en !== 1'b1 || rd_bank !== 1'b0 || rd_mod !== 2'd3
                || rd_addr !== 8'(k - 145)) rd_bad++;
         end else if (k >= 289 && k <= 312) begin
            if (rd_en !== 1'b1 || rd_bank !== 1'b1 || rd_mod !== 2'd0
                || rd_addr !== 8'(k - 289)) rd_bad++;
         end else if (rd_en !== 1'b0) rd_bad++;
         if (rd_en === 1'b1 && rd_bank === 1'b0) n0++;
         if (rd_en === 1'b1 && rd_bank === 1'b1) n1++;
      end
      total++;
      if (wr_bad !== 0) begin
         bad++;
         $display("FAIL rchg_writes: got=%0d bad cycles want=0", wr_bad);
      end
      total++;
      if (rd_bad !== 0) begin
         bad++;
         $display("FAIL rchg_reads: got=%0d bad cycles want=0", rd_bad);
      end
      total++;
      if (n0 !== 144 || n1 !== 24) begin
         bad++;
         $display("FAIL rchg_npair: got=%0d/%0d want=144/24", n0, n1);
      end
   endtask

   task automatic test_bad_rate();
      int err_bad, wr_bad, rd_bad;
      apply_reset();
      err_bad = 0; wr_bad = 0; rd_bad = 0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         reset = 1'b0;
         rate = 4'b0000;
         in_valid = 1'b1;
         #1;
         if (rate_err !== 1'b1 || wr_en !== 1'b0 || in_ready !== 1'b0) err_bad++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (rate_err !== 1'b0) err_bad++;
      total++;
      if (err_bad !== 0) begin
         bad++;
         $display("FAIL badrate_err: got=%0d bad cycles want=0", err_bad);
      end
      for (int k = 0; k < 110; k++) begin
         @(negedge clk);
         rate = 4'b0101;
         in_valid = (k < 48);
         #1;
         if (rate_err !== 1'b0) wr_bad++;
         if (k < 48) begin
            if (wr_en !== 1'b1 || wr_bank !== 1'b0 || wr_addr !== 8'(k)) wr_bad++;
         end else if (wr_en !== 1'b0) wr_bad++;
         if (k >= 49 && k <= 96) begin
            if (rd_en !== 1'b1 || rd_mod !== 2'd1 || rd_addr !== 8'(k - 49)) rd_bad++;
         end else if (rd_en !== 1'b0) rd_bad++;
      end
      total++;
      if (wr_bad !== 0) begin
         bad++;
         $display("FAIL badrate_resume_wr: got=%0d bad cycles want=0", wr_bad);
      end
      total++;
      if (rd_bad !== 0) begin
         bad++;
         $display("FAIL badrate_resume_rd: got=%0d bad cycles want=0", rd_bad);
      end
   endtask

   task automatic test_both_full();
      int rdy_bad, wr_bad, rd_bad;
      logic exp_rdy;
      apply_reset();
      rdy_bad = 0; wr_bad = 0; rd_bad = 0;
      for (int k = 0; k < 230; k++) begin
         @(negedge clk);
         reset = 1'b0;
         rate = (k < 144) ? 4'b0001 : 4'b1101;
         in_valid = 1'b1;
         #1;
         exp_rdy = (k < 168);
         if (in_ready !== exp_rdy) rdy_bad++;
         if (wr_en !== exp_rdy) wr_bad++;
         if (rd_en !== (k >= 145)) rd_bad++;
      end
      total++;
      if (rdy_bad !== 0) begin
         bad++;
         $display("FAIL full_in_ready: got=%0d bad cycles want=0", rdy_bad);
      end
      total++;
      if (wr_bad !== 0) begin
         bad++;
         $display("FAIL full_no_write: got=%0d bad cycles want=0", wr_bad);
      end
      total++;
      if (rd_bad !== 0) begin
         bad++;
         $display("FAIL full_reads: got=%0d bad cycles want=0", rd_bad);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] got;
      int first_rd;
      apply_reset();
      for (int k = 0; k < 146; k++) begin
         @(negedge clk);
         reset = 1'b0;
         rate = 4'b1001;
         in_valid = 1'b1;
         #1;
      end
      total++;
      if (wr_addr !== 8'd49 || wr_bank !== 1'b1 || rd_en !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre: got=%0d/%b/%b want=49/1/1",
                  wr_addr, wr_bank, rd_en);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      got = {in_ready, wr_en, rd_en, out_valid, sym_start, rate_err,
             wr_bank, rd_bank, rd_mod, wr_addr, rd_addr, 6'd0};
      total++;
      if (got !== 32'd0) begin
         bad++;
         $display("FAIL mid_in_reset: got=%h want=0", got);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      got = {rd_en, out_valid, sym_start, rate_err, rd_bank, rd_mod, rd_addr};
      total++;
      if (got !== 32'd0) begin
         bad++;
         $display("FAIL mid_after_reset: got=%h want=0", got);
      end
      total++;
      if (in_ready !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 8'd0
          || wr_bank !== 1'b0) begin
         bad++;
         $display("FAIL mid_restart_wr: got=%b/%b/%0d/%b want=1/1/0/0",
                  in_ready, wr_en, wr_addr, wr_bank);
      end
      first_rd = -1;
      for (int j = 1; j < 110; j++) begin
         @(negedge clk);
         in_valid = (j < 96);
         #1;
         if (rd_en === 1'b1 && first_rd < 0) begin
            first_rd = j;
            total++;
            if (rd_bank !== 1'b0 || rd_addr !== 8'd0 || rd_mod !== 2'd2) begin
               bad++;
               $display("FAIL mid_first_read: got=%b/%0d/%0d want=0/0/2",
                        rd_bank, rd_addr, rd_mod);
            end
         end
      end
      total++;
      if (first_rd !== 97) begin
         bad++;
         $display("FAIL mid_first_rd_cycle: got=%0d want=97", first_rd);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      rate = 4'b0000;
      in_valid = 1'b0;
      test_reset();
      test_16qam();
      test_back_to_back();
      test_rate_change();
      test_bad_rate();
      test_both_full();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ilv_bank_ctrl.md
ILV_BANK_CTRL -- requirements
Module: ilv_bank_ctrl

Interface
REQ-001 Parameter: ADDR_W, 8, pair-address width; must cover 144 pairs.
REQ-002 Clk  input  1  single system clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rate  input  4  802.11a RATE code, sampled at the first write of each symbol.
REQ-005 in_valid  input  1  encoder A/B bit pair present this cycle.
REQ-006 in_ready  output  1  controller accepts the pair this cycle; transfer = in_valid & in_ready.
REQ-007 wr_en, wr_bank, wr_addr  output  1/1/ADDR_W  write strobe, ping-pong bank select, pair address.
REQ-008 rd_en, rd_bank, rd_addr  output  1/1/ADDR_W  read strobe, bank select, sequential pair index for the permutation stage.
REQ-009 rd_mod  output  2  modulation of the bank being read: 0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM.
REQ-010 out_valid  output  1  memory data valid; rd_en delayed one cycle.
REQ-011 sym_start  output  1  one-cycle pulse with the rd_en of read index 0.
REQ-012 rate_err  output  1  one-cycle pulse when an illegal rate is sampled.

Function
REQ-013 Decode rate: 1101/1111 -> BPSK, NPAIR 24; 0101/0111 -> QPSK, 48; 1001/1011 -> 16QAM, 96; 0001/0011 -> 64QAM, 144; any other code is illegal.
REQ-014 Two banks, each with full flag, latched mod and NPAIR; write pointer wb and read pointer rb, both 0 after reset.
REQ-015 in_ready = !full[wb] and, when wr_addr==0, rate legal.
REQ-016 On transfer: wr_en=1, wr_bank=wb, wr_addr=write counter, combinational same cycle as the transfer.
REQ-017 At a transfer with wr_addr==0, latch mod/NPAIR of rate into bank wb; rate changes during a symbol are ignored.
REQ-018 Illegal rate with in_valid=1 and wr_addr==0: no transfer, rate_err=1 that cycle, state unchanged.
REQ-019 Transfer with wr_addr==NPAIR[wb]-1: set full[wb], write counter to 0, toggle wb.
REQ-020 in_valid gaps hold the write counter; no timeout.
REQ-021 Read FSM states: IDLE (rd_en=0), READ (rd_en=1 every cycle).
REQ-022 IDLE -> READ when full[rb]; first read cycle is the cycle after full[rb] becomes 1.
REQ-023 READ: rd_bank=rb, rd_addr increments 0..NPAIR[rb]-1, rd_mod = mod[rb]; no read stall.
REQ-024 On last read index: clear full[rb], toggle rb, counter to 0; stay READ if the other bank is full that cycle, else IDLE.
REQ-025 Back-to-back full banks are read with no idle cycle between symbols.
REQ-026 Same-cycle set of full[wb] and clear of full[rb] both take effect (distinct banks).
REQ-027 Write of a bank is blocked while it is full; no overwrite of unread data.
REQ-028 out_valid and the sym_start pulse are registered copies of rd_en / (rd_en & rd_addr==0), 1-cycle latency.

Reset
REQ-029 During reset: in_ready=0, wr_en=0, rd_en=0, out_valid=0, sym_start=0, rate_err=0; addresses, rd_mod, wb, rb, full flags all 0; FSM IDLE.
REQ-030 Reset mid-symbol discards partial and unread banks; first cycle after reset in_ready=1.

Structure
REQ-031 Package ilv_pkg holds the 4-bit rate code constants, modulation encoding, NPAIR constants (24/48/96/144), and the read-FSM state type.
REQ-032 One sub-module ilv_rate_decode (combinational rate -> {legal, mod, npair}), instantiated once on the write side.

Verification
REQ-033 Reset, rate=1001, continuous in_valid for 192 cycles -> bank0 addr 0..95, then bank1; first rd_en cycle 97 (after fill), rd_mod=2, sym_start once per 96 reads, out_valid 1 cycle after rd_en.
REQ-034 rate=1101 continuous for 10 symbols -> reads 24 pairs per symbol, rb toggles, no rd_en gap after the first symbol, in_ready stays 1.
REQ-035 rate 0001 then 1101 at the next symbol boundary -> first read bank NPAIR 144/rd_mod 3, second 24/rd_mod 0; rate changed mid-symbol has no effect.
REQ-036 rate=0000 at symbol start -> rate_err pulses each valid cycle, no wr_en; switch to 0101 -> writes resume at addr 0, rd_mod=1.
REQ-037 Hold in_valid=1 with reads blocked by both banks full (inject via 144-pair bank then check) -> in_ready=0 while full[wb], no wr_en to full bank.
REQ-038 Assert reset at wr_addr=50 while reading -> all outputs zero next cycle; new symbol restarts at bank0 addr 0.
